// File: rtl/imem_loader.sv
// Instruction-memory boot loader: parses a length-prefixed, XOR-checksummed byte
// stream into 32-bit little-endian words and writes them into instruction memory.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   word_idx_q;
  logic [1:0]         byte_idx_q;
  logic [7:0]         xor_q;
  logic [23:0]        word_q;
  logic               rx_ready_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               core_reset_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic               accept_c;
  logic [CNT_W-1:0]   count_full_c;
  logic               last_word_c;

  // rx_ready_q mirrors the current state, so it is the live handshake term
  assign accept_c     = rx_valid & rx_ready_q;
  assign count_full_c = {rx_data, count_q[7:0]};
  assign last_word_c  = (word_idx_q + CNT_W'(1)) == count_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept_c) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept_c) begin
          if (32'(count_full_c) > 32'(MAX_WORDS)) state_d = S_ERR;
          else if (count_full_c == '0)            state_d = S_CSUM;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept_c && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word_c ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept_c) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decode the next state)
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      xor_q        <= '0;
      word_q       <= '0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_CSUM);
      busy_q       <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_WRITE)  ||
                      (state_d == S_CSUM);
      mem_we_q     <= (state_d == S_WRITE);
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      core_reset_q <= (state_d != S_DONE);

      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept_c) count_q[7:0] <= rx_data;
        end
        S_LEN_HI: begin
          if (accept_c) count_q[15:8] <= rx_data;
        end
        S_DATA: begin
          if (accept_c) begin
            xor_q      <= xor_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            word_q     <= {rx_data, word_q[23:8]};
            // Bytes arrive LSB first; the fourth byte completes the word
            if (byte_idx_q == 2'd3) begin
              mem_wdata_q <= {rx_data, word_q};
              mem_addr_q  <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            end
          end
        end
        S_WRITE: begin
          word_idx_q <= word_idx_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames, expected memory writes queued per frame
// and popped by a write monitor, plus hand-written reset and restart sequences.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 256;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    int          nb;
    logic [95:0] bytes;      // byte 0 of the frame in [7:0]
    bit          toggle;
    bit          pulse;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t tab[9];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write
  always @(negedge clk_in) begin
    if (reset === 1'b0 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input logic [95:0] b, input int k);
    return b[8*k +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit toggle);
    int g = 0;
    if (toggle) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = d;
    while (rx_ready !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    if (g >= 40) begin
      nvec++;
      nfail++;
      $display("FAIL rx_ready_timeout: got rx_ready %b expected 1 within 40 cycles", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] count;
    logic [31:0] w;
    count = {byte_at(v.bytes, 1), byte_at(v.bytes, 0)};
    if (v.nb >= 2 && 32'(count) <= MAXW) begin
      for (int i = 0; i < int'(count); i++) begin
        if (2 + 4*i + 3 < v.nb) begin
          w = {byte_at(v.bytes, 2+4*i+3), byte_at(v.bytes, 2+4*i+2),
               byte_at(v.bytes, 2+4*i+1), byte_at(v.bytes, 2+4*i)};
          exp_q.push_back('{addr: BASE + 32'(4*i), data: w});
        end
      end
    end
    pulse_start();
    chk({v.name, "_start_busy"}, 32'(busy), 32'd1);
    chk({v.name, "_start_core_reset"}, 32'(core_reset), 32'd1);
    chk({v.name, "_start_done"}, 32'(done), 32'd0);
    for (int i = 0; i < v.nb; i++) begin
      send_byte(byte_at(v.bytes, i), v.toggle);
      if (v.pulse && i == 4) pulse_start();
    end
    chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "_core_reset"}, 32'(core_reset), 32'(!v.exp_done));
    chk({v.name, "_busy"}, 32'(busy), 32'd0);
    chk({v.name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({v.name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frames are listed last byte first so byte 0 lands in [7:0]
    tab[0] = '{"basic", 11, {8'hC0,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'h13,8'h00,8'h02}, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[1] = '{"bad_csum", 11, {8'hC1,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'h13,8'h00,8'h02}, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[2] = '{"zero_cnt", 3, {8'h00,8'h00,8'h00}, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[3] = '{"too_long", 2, {8'h01,8'h01}, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[4] = '{"toggled", 11, {8'hC0,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'h13,8'h00,8'h02}, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[5] = '{"one_word", 7, {8'h22,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h01}, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[6] = '{"restart", 11, {8'hC0,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'h13,8'h00,8'h02}, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[7] = '{"zero_bad", 3, {8'h05,8'h00,8'h00}, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[8] = '{"after_err", 11, {8'hC0,8'h00,8'h50,8'h00,8'h93,8'h00,8'h10,8'h00,8'h13,8'h00,8'h02}, 1'b1, 1'b0, 1'b1, 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_rx_ready", 32'(rx_ready), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(tab[i]);
      tick();
    end

    // Reset in the middle of the second word: first word stays written once
    exp_q.push_back('{addr: BASE, data: 32'h0010_0013});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, BASE);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_writes_left", 32'(exp_q.size()), 32'd0);

    run_vec(tab[0]);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
